wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/rr_prio_enc.sv | 39 +++
 rtl/wb_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared state type and Wishbone width constants for the round-robin arbiter.
package wb_arb_pkg;
    localparam int WB_AW          = 32;
    localparam int WB_DW          = 32;
    localparam int WB_SW          = 4;
    localparam int WB_MAX_MASTERS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_prio_enc.sv
// Rotate-and-priority encoder: picks the first requester after last_i,
// searching upward and wrapping to index 0.
module rr_prio_enc
    import wb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);
    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IW:0]    base;
    logic [IW:0]    sum;
    logic [IW-1:0]  pos;

    // Doubling the vector turns the wrap-around into a plain window select.
    assign base    = {1'b0, last_i} + 1'b1;
    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl[base +: N];

    always_comb begin
        pos = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pos = IW'(i);
            end
        end
    end

    assign sum     = base + {1'b0, pos};
    assign valid_o = |req_i;
    assign idx_o   = (sum >= N_W) ? IW'(sum - N_W) : sum[IW-1:0];
endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter, N masters onto one slave with bus lock.
// Define WB_ARB_TIMEOUT_EN to abort transfers the slave never answers.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int C_NUM_MASTERS = 2,
    parameter int C_TIMEOUT     = 255
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic [C_NUM_MASTERS-1:0]       m_cyc_i,
    input  logic [C_NUM_MASTERS-1:0]       m_stb_i,
    input  logic [C_NUM_MASTERS-1:0]       m_we_i,
    input  logic [WB_SW*C_NUM_MASTERS-1:0] m_sel_i,
    input  logic [WB_AW*C_NUM_MASTERS-1:0] m_adr_i,
    input  logic [WB_DW*C_NUM_MASTERS-1:0] m_dat_i,
    output logic [WB_DW-1:0]               m_dat_o,
    output logic [C_NUM_MASTERS-1:0]       m_ack_o,
    output logic [C_NUM_MASTERS-1:0]       m_err_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    output logic                           s_we_o,
    output logic [WB_SW-1:0]               s_sel_o,
    output logic [WB_AW-1:0]               s_adr_o,
    output logic [WB_DW-1:0]               s_dat_o,
    input  logic [WB_DW-1:0]               s_dat_i,
    input  logic                           s_ack_i,
    input  logic                           s_err_i
);
    localparam int IW = $clog2(C_NUM_MASTERS);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic          enc_valid;
    logic [IW-1:0] enc_idx;
    logic          busy;
    logic          timeout_hit;

    logic [WB_SW-1:0] sel_arr [C_NUM_MASTERS];
    logic [WB_AW-1:0] adr_arr [C_NUM_MASTERS];
    logic [WB_DW-1:0] dat_arr [C_NUM_MASTERS];

    rr_prio_enc #(.N(C_NUM_MASTERS), .IW(IW)) u_enc (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    // Reset masks everything so an abandoned transfer never sees ack/err.
    assign busy    = (state_q == BUSY) && !wb_rst_i;
    assign m_dat_o = s_dat_i;

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_MASTERS; gi++) begin : g_master
            assign sel_arr[gi] = m_sel_i[WB_SW*gi +: WB_SW];
            assign adr_arr[gi] = m_adr_i[WB_AW*gi +: WB_AW];
            assign dat_arr[gi] = m_dat_i[WB_DW*gi +: WB_DW];
            assign m_ack_o[gi] = busy && (grant_q == IW'(gi)) && s_ack_i && !timeout_hit;
            assign m_err_o[gi] = busy && (grant_q == IW'(gi)) && (s_err_i || timeout_hit);
        end
    endgenerate

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(C_TIMEOUT + 1);

    logic [CW-1:0] tmo_q, tmo_d;

    assign timeout_hit = busy && (tmo_q == CW'(C_TIMEOUT));

    always_comb begin
        tmo_d = tmo_q;
        if ((state_q != BUSY) || (state_d != BUSY) || s_ack_i || s_err_i) begin
            tmo_d = '0;
        end else if (s_stb_o) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (busy) begin
            s_cyc_o = m_cyc_i[grant_q] && !timeout_hit;
            s_stb_o = m_stb_i[grant_q] && !timeout_hit;
            s_we_o  = m_we_i[grant_q];
            s_sel_o = sel_arr[grant_q];
            s_adr_o = adr_arr[grant_q];
            s_dat_o = dat_arr[grant_q];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    grant_d = enc_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!m_cyc_i[grant_q] || timeout_hit) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(C_NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: ack scoreboard plus grant-timing checks.
module tb_wb_rr_arbiter;
    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        cyc_a [2];
    logic        stb_a [2];
    logic        we_a  [2];
    logic [31:0] adr_a [2];
    logic [31:0] dat_a [2];
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [7:0]  m_sel;
    logic [63:0] m_adr, m_dat;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o, m_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat;
    logic        s_ack, s_err;
    logic        slv_en = 1'b0;
    logic        ack_force = 1'b0;
    logic [31:0] mem [16];

    typedef struct {
        bit          m;
        bit          rd;
        logic [31:0] dat;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;

    assign m_cyc = {cyc_a[1], cyc_a[0]};
    assign m_stb = {stb_a[1], stb_a[0]};
    assign m_we  = {we_a[1], we_a[0]};
    assign m_sel = 8'hFF;
    assign m_adr = {adr_a[1], adr_a[0]};
    assign m_dat = {dat_a[1], dat_a[0]};

    // Zero-wait slave backed by a small memory.
    assign s_ack = (slv_en & s_cyc_o & s_stb_o) | ack_force;
    assign s_err = 1'b0;
    assign s_dat = mem[s_adr_o[5:2]];

    always @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (s_ack && s_cyc_o && s_we_o) begin
            mem[s_adr_o[5:2]] <= s_dat_o;
        end
    end

    wb_rr_arbiter #(.C_NUM_MASTERS(2), .C_TIMEOUT(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (srst),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_we_i   (m_we),
        .m_sel_i  (m_sel),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat),
        .s_ack_i  (s_ack),
        .s_err_i  (s_err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_m(input bit m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        cyc_a[m] = cyc;
        stb_a[m] = stb;
        we_a[m]  = we;
        adr_a[m] = adr;
        dat_a[m] = dat;
    endtask

    task automatic push(input bit m, input bit rd, input logic [31:0] dat);
        exp_t e;
        e.m   = m;
        e.rd  = rd;
        e.dat = dat;
        sb_q.push_back(e);
    endtask

    // Response monitor: every ack pulse must match the oldest expected transfer.
    initial forever begin
        exp_t        e;
        logic [1:0]  exp_ack;
        at_neg();
        if (m_err_o !== 2'b00) err_cnt++;
        if (m_ack_o !== 2'b00) begin
            exp_ack = 2'b00;
            e.m = 1'b0; e.rd = 1'b0; e.dat = '0;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                exp_ack[e.m] = 1'b1;
            end
            chk("ack_who", 32'(m_ack_o), 32'(exp_ack));
            if (e.rd) chk("rd_dat", m_dat_o, e.dat);
            $display("ack m_ack_o=%b m_dat_o=%h", m_ack_o, m_dat_o);
        end
    end

    initial begin
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);

        // Reset state
        tick(); tick(); at_neg();
        chk("rst_scyc", 32'(s_cyc_o), 32'd0);
        chk("rst_ackerr", 32'({m_ack_o, m_err_o}), 32'd0);
        chk("rst_sadr", s_adr_o, 32'd0);
        tick(); srst = 1'b0;

        // Single master 0 write then read back
        set_m(0, 1, 1, 1, 32'h0, 32'hDEAD_BEEF);
        at_neg(); chk("t1_stb_idle", 32'(s_stb_o), 32'd0);
        tick(); at_neg();
        chk("t1_stb", 32'(s_stb_o), 32'd1);
        chk("t1_we", 32'(s_we_o), 32'd1);
        chk("t1_sel", 32'(s_sel_o), 32'hF);
        chk("t1_adr", s_adr_o, 32'h0);
        chk("t1_dat", s_dat_o, 32'hDEAD_BEEF);
        tick(); slv_en = 1'b1; push(0, 0, 32'h0);
        tick(); set_m(0, 1, 1, 0, 32'h0, 32'h0); push(0, 1, 32'hDEAD_BEEF);
        tick(); set_m(0, 0, 0, 0, 32'h0, 32'h0); slv_en = 1'b0;
        tick(); at_neg(); chk("t1_idle", 32'(s_cyc_o), 32'd0);

        // Simultaneous requests from reset: master 0 first, one idle cycle, then master 1
        srst = 1'b1; tick(); srst = 1'b0;
        set_m(0, 1, 1, 0, 32'h4, 32'h0);
        set_m(1, 1, 1, 0, 32'h8, 32'h0);
        at_neg(); chk("t2_idle", 32'(s_cyc_o), 32'd0);
        tick(); at_neg(); chk("t2_g0_adr", s_adr_o, 32'h4);
        tick(); slv_en = 1'b1; push(0, 1, 32'hA000_0001);
        tick(); slv_en = 1'b0; set_m(0, 0, 0, 0, 32'h4, 32'h0);
        at_neg(); chk("t2_rel_cyc", 32'(s_cyc_o), 32'd0);
        tick(); at_neg(); chk("t2_gap", 32'(s_cyc_o), 32'd0);
        tick(); at_neg();
        chk("t2_g1_cyc", 32'(s_cyc_o), 32'd1);
        chk("t2_g1_adr", s_adr_o, 32'h8);
        tick(); slv_en = 1'b1; push(1, 1, 32'hA000_0002);
        tick(); slv_en = 1'b0; set_m(1, 0, 0, 0, 32'h8, 32'h0);
        tick();

        // Bus lock: master 1 strobes three times while master 0 waits
        set_m(1, 1, 0, 0, 32'h0, 32'h0);
        tick();
        set_m(0, 1, 1, 0, 32'h10, 32'h0);
        slv_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_m(1, 1, 1, 1, 32'h10 + 32'(4*k), 32'hC0DE_0000 + 32'(k));
            push(1, 0, 32'h0);
            at_neg(); chk("t3_lock_adr", s_adr_o, 32'h10 + 32'(4*k));
            tick();
        end
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        at_neg(); chk("t3_no_preempt", 32'(s_cyc_o), 32'd0);
        tick(); at_neg(); chk("t3_gap", 32'(s_cyc_o), 32'd0);
        tick(); push(0, 1, 32'hC0DE_0000);
        at_neg(); chk("t3_g0_adr", s_adr_o, 32'h10);
        tick(); set_m(0, 0, 0, 0, 32'h10, 32'h0); slv_en = 1'b0;
        tick();

        // Cyc drop coincident with ack
        set_m(0, 1, 1, 0, 32'h14, 32'h0);
        tick();
        set_m(0, 0, 0, 0, 32'h14, 32'h0); ack_force = 1'b1; push(0, 1, 32'hC0DE_0001);
        tick(); ack_force = 1'b0; set_m(1, 1, 1, 0, 32'h8, 32'h0);
        at_neg();
        chk("t4_idle_cyc", 32'(s_cyc_o), 32'd0);
        chk("t4_idle_ack", 32'(m_ack_o), 32'd0);
        tick(); at_neg(); chk("t4_next_adr", s_adr_o, 32'h8);
        tick(); set_m(1, 0, 0, 0, 32'h8, 32'h0);
        tick();

        // Unresponsive slave
        set_m(0, 1, 1, 0, 32'h4, 32'h0);
        set_m(1, 1, 1, 0, 32'h8, 32'h0);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("t5_stall_err", 32'(m_err_o), 32'd0);
            chk("t5_stall_cyc", 32'(s_cyc_o), 32'd1);
            tick();
        end
        at_neg();
        chk("t5_err", 32'(m_err_o), 32'd1);
        chk("t5_cyc_drop", 32'(s_cyc_o), 32'd0);
        chk("t5_stb_drop", 32'(s_stb_o), 32'd0);
        tick(); set_m(0, 0, 0, 0, 32'h4, 32'h0);
        at_neg(); chk("t5_err_once", 32'(m_err_o), 32'd0);
        tick(); at_neg();
        chk("t5_next_cyc", 32'(s_cyc_o), 32'd1);
        chk("t5_next_adr", s_adr_o, 32'h8);
        tick(); set_m(1, 0, 0, 0, 32'h8, 32'h0);
        tick(); tick();
`else
        for (int i = 0; i < 10; i++) begin
            at_neg();
            chk("t5_hold_err", 32'(m_err_o), 32'd0);
            chk("t5_hold_adr", s_adr_o, 32'h4);
            tick();
        end
        set_m(0, 0, 0, 0, 32'h4, 32'h0);
        set_m(1, 0, 0, 0, 32'h8, 32'h0);
        tick(); tick();
`endif

        // Reset while busy
        set_m(1, 1, 1, 0, 32'h8, 32'h0);
        tick();
        srst = 1'b1; ack_force = 1'b1;
        set_m(0, 1, 1, 0, 32'h4, 32'h0);
        at_neg();
        chk("t6_rst_cyc", 32'(s_cyc_o), 32'd0);
        chk("t6_rst_stb", 32'(s_stb_o), 32'd0);
        chk("t6_rst_ackerr", 32'({m_ack_o, m_err_o}), 32'd0);
        chk("t6_rst_adr", s_adr_o, 32'd0);
        tick(); srst = 1'b0;
        at_neg();
        chk("t6_post_cyc", 32'(s_cyc_o), 32'd0);
        chk("t6_post_ack", 32'(m_ack_o), 32'd0);
        tick(); ack_force = 1'b0;
        at_neg(); chk("t6_prio0_adr", s_adr_o, 32'h4);
        tick();
        set_m(0, 0, 0, 0, 32'h4, 32'h0);
        set_m(1, 0, 0, 0, 32'h8, 32'h0);
        tick(); tick();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef WB_ARB_TIMEOUT_EN
        chk("err_total", 32'(err_cnt), 32'd1);
`else
        chk("err_total", 32'(err_cnt), 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
